// File: rtl/bist_pkg.sv
// Shared types and defaults for the parametrised BIST controller.
// Holds the FSM state enum and the Galois MISR next-state function.
package bist_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        COMPARE,
        DONE
    } bist_state_t;

    localparam logic [8:0] DEF_LFSR_TAPS = 9'h110;
    localparam logic [8:0] DEF_LFSR_SEED = 9'h1FF;
    localparam logic [3:0] DEF_MISR_TAPS = 4'h3;
    localparam logic [3:0] DEF_GOLDEN    = 4'b0101;

    // Width-agnostic step; callers truncate the result to their own width.
    function automatic logic [31:0] misr_next(
        input logic [31:0] sig,
        input logic [31:0] taps,
        input logic [31:0] data,
        input int          width
    );
        logic [31:0] nxt;
        nxt = sig << 1;
        if (sig[5'(width - 1)]) nxt = nxt ^ taps;
        return nxt ^ data;
    endfunction

endpackage

// File: rtl/bist_misr.sv
// Galois multiple-input signature register compacting DUT responses.
// clr has priority over en; the signature holds otherwise.
module bist_misr
    import bist_pkg::*;
#(
    parameter int               RES_W     = 4,
    parameter logic [RES_W-1:0] MISR_TAPS = RES_W'(DEF_MISR_TAPS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [RES_W-1:0] data_in,
    output logic [RES_W-1:0] sig
);

    logic [RES_W-1:0] sig_d;
    logic [RES_W-1:0] sig_q;

    always_comb begin
        sig_d = sig_q;
        if (clr) begin
            sig_d = '0;
        end else if (en) begin
            sig_d = RES_W'(misr_next(32'(sig_q), 32'(MISR_TAPS),
                                     32'(data_in), RES_W));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) sig_q <= '0;
        else     sig_q <= sig_d;
    end

    assign sig = sig_q;

endmodule

// File: rtl/bist_controller_param.sv
// BIST controller: LFSR patterns into a combinational DUT, MISR compaction,
// and a golden-signature verdict behind a start/busy/done handshake.
module bist_controller_param
    import bist_pkg::*;
#(
    parameter int               PAT_W      = 9,
    parameter int               RES_W      = 4,
    parameter int               N_PATTERNS = 511,
    parameter logic [PAT_W-1:0] LFSR_TAPS  = PAT_W'(DEF_LFSR_TAPS),
    parameter logic [PAT_W-1:0] LFSR_SEED  = PAT_W'(DEF_LFSR_SEED),
    parameter logic [RES_W-1:0] MISR_TAPS  = RES_W'(DEF_MISR_TAPS),
    parameter logic [RES_W-1:0] GOLDEN     = RES_W'(DEF_GOLDEN),
    parameter int               CNT_W      = $clog2(N_PATTERNS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bist_mode,
    input  logic             start,
    input  logic [RES_W-1:0] result_dut,
    output logic [PAT_W-1:0] pattern_out,
    output logic             pattern_valid,
    output logic [RES_W-1:0] misr_output,
    output logic [CNT_W-1:0] pattern_count,
    output logic             busy,
    output logic             done,
    output logic             fault_detected
);

    if (LFSR_SEED == '0) begin : g_bad_seed
        $error("LFSR_SEED must be nonzero");
    end

    bist_state_t      state_d, state_q;
    logic [PAT_W-1:0] lfsr_d, lfsr_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic             fault_d, fault_q;
    logic             misr_clr, misr_en;
    logic [RES_W-1:0] misr_sig;

    always_comb begin
        state_d  = state_q;
        lfsr_d   = lfsr_q;
        cnt_d    = cnt_q;
        fault_d  = fault_q;
        misr_clr = 1'b0;
        misr_en  = 1'b0;
        if (!bist_mode) begin
            // Abort: drop the verdict but keep misr/count for inspection.
            state_d = IDLE;
            fault_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_d  = RUN;
                        lfsr_d   = LFSR_SEED;
                        cnt_d    = '0;
                        fault_d  = 1'b0;
                        misr_clr = 1'b1;
                    end
                end
                RUN: begin
                    misr_en = 1'b1;
                    lfsr_d  = {lfsr_q[PAT_W-2:0], ^(lfsr_q & LFSR_TAPS)};
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(N_PATTERNS - 1)) state_d = COMPARE;
                end
                COMPARE: begin
                    fault_d = (misr_sig != GOLDEN);
                    state_d = DONE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            lfsr_q  <= LFSR_SEED;
            cnt_q   <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
        end
    end

    bist_misr #(
        .RES_W    (RES_W),
        .MISR_TAPS(MISR_TAPS)
    ) u_misr (
        .clk    (clk),
        .rst    (rst),
        .clr    (misr_clr),
        .en     (misr_en),
        .data_in(result_dut),
        .sig    (misr_sig)
    );

    assign pattern_out    = lfsr_q;
    assign pattern_valid  = (state_q == RUN);
    assign misr_output    = misr_sig;
    assign pattern_count  = cnt_q;
    assign busy           = (state_q == RUN) || (state_q == COMPARE);
    assign done           = (state_q == DONE);
    assign fault_detected = fault_q;

endmodule

// File: tb/tb_bist_controller_param.sv
// Scoreboard bench for bist_controller_param: default-size and 4-pattern
// instances driven against an in-bench AU, LFSR and MISR model.
module tb_bist_controller_param;

    localparam int PAT_W   = 9;
    localparam int RES_W   = 4;
    localparam int N_FULL  = 511;
    localparam int N_SMALL = 4;
    localparam int CW_F    = $clog2(N_FULL + 1);
    localparam int CW_S    = $clog2(N_SMALL + 1);
    localparam logic [RES_W-1:0] GOLD = 4'b0101;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst, mode, start, inject;
    logic [RES_W-1:0] res;
    logic [PAT_W-1:0] pat;
    logic             pv, busy, done, fault;
    logic [RES_W-1:0] misr;
    logic [CW_F-1:0]  cnt;

    logic             mode_s, start_s;
    logic [RES_W-1:0] res_s;
    logic [PAT_W-1:0] pat_s;
    logic             pv_s, busy_s, done_s, fault_s;
    logic [RES_W-1:0] misr_s;
    logic [CW_S-1:0]  cnt_s;

    int n_checks = 0;
    int n_fail   = 0;

    logic [PAT_W-1:0] pat_q[$];
    logic [RES_W-1:0] sig_q[$];
    logic [RES_W-1:0] sig_clean;

    bist_controller_param dut (
        .clk(clk), .rst(rst), .bist_mode(mode), .start(start),
        .result_dut(res), .pattern_out(pat), .pattern_valid(pv),
        .misr_output(misr), .pattern_count(cnt), .busy(busy),
        .done(done), .fault_detected(fault)
    );

    bist_controller_param #(.N_PATTERNS(N_SMALL)) dut_s (
        .clk(clk), .rst(rst), .bist_mode(mode_s), .start(start_s),
        .result_dut(res_s), .pattern_out(pat_s), .pattern_valid(pv_s),
        .misr_output(misr_s), .pattern_count(cnt_s), .busy(busy_s),
        .done(done_s), .fault_detected(fault_s)
    );

    function automatic logic [PAT_W-1:0] lfsr_step(input logic [PAT_W-1:0] x);
        return {x[PAT_W-2:0], ^(x & 9'h110)};
    endfunction

    function automatic logic [RES_W-1:0] misr_step(input logic [RES_W-1:0] m,
                                                   input logic [RES_W-1:0] d);
        return {m[RES_W-2:0], 1'b0} ^ (m[RES_W-1] ? 4'h3 : 4'h0) ^ d;
    endfunction

    // Toy AU: add or subtract two nibbles; inj forces result bit 0 stuck-at-0.
    function automatic logic [RES_W-1:0] au(input logic [PAT_W-1:0] p,
                                            input logic inj);
        logic [RES_W-1:0] r;
        r = p[8] ? (p[3:0] - p[7:4]) : (p[3:0] + p[7:4]);
        if (inj) r[0] = 1'b0;
        return r;
    endfunction

    always_comb res   = au(pat, inject);
    always_comb res_s = au(pat_s, 1'b0);

    task automatic push_run(input int n, input logic inj);
        logic [PAT_W-1:0] l;
        logic [RES_W-1:0] m;
        l = 9'h1FF;
        m = '0;
        pat_q.delete();
        sig_q.delete();
        for (int i = 0; i < n; i++) begin
            pat_q.push_back(l);
            m = misr_step(m, au(l, inj));
            l = lfsr_step(l);
        end
        sig_q.push_back(m);
    endtask

    task automatic check_pat(input logic [PAT_W-1:0] got, input string nm);
        logic [PAT_W-1:0] e;
        n_checks++;
        if (pat_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: got pattern %h, none expected", nm, got);
        end else begin
            e = pat_q.pop_front();
            if (got !== e) begin
                n_fail++;
                $display("FAIL %s: got %h, want %h", nm, got, e);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; mode = 1'b0; start = 1'b0; inject = 1'b0;
        mode_s = 1'b0; start_s = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({pv, busy, done, fault, misr, cnt} !== '0) begin
            n_fail++;
            $display("FAIL reset_outs: got %b, want 0",
                     {pv, busy, done, fault, misr, cnt});
        end
        n_checks++;
        if (pat !== 9'h1FF || pat_s !== 9'h1FF) begin
            n_fail++;
            $display("FAIL reset_pat: got %h/%h, want 1ff", pat, pat_s);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_small_run();
        int cyc;
        push_run(N_SMALL, 1'b0);
        mode_s = 1'b1;
        start_s = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
        cyc = 0;
        while (!done_s && cyc < 20) begin
            if (pv_s) check_pat(pat_s, "small_pat");
            @(negedge clk);
            cyc++;
        end
        n_checks++;
        if (cyc != N_SMALL + 1 || pat_q.size() != 0) begin
            n_fail++;
            $display("FAIL small_latency: got %0d cycles (%0d left), want %0d",
                     cyc, pat_q.size(), N_SMALL + 1);
        end
        n_checks++;
        if (cnt_s !== CW_S'(N_SMALL) || misr_s !== sig_q[0]) begin
            n_fail++;
            $display("FAIL small_final: got cnt %0d sig %h, want %0d %h",
                     cnt_s, misr_s, N_SMALL, sig_q[0]);
        end
    endtask

    task automatic run_full(input logic inj, input string nm,
                            output logic [RES_W-1:0] got_sig);
        int cyc;
        logic [RES_W-1:0] e;
        push_run(N_FULL, inj);
        inject = inj;
        mode = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (!done && cyc < N_FULL + 20) begin
            if (pv) check_pat(pat, nm);
            @(negedge clk);
            cyc++;
        end
        n_checks++;
        if (cyc != N_FULL + 1 || done !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_latency: got %0d cycles done=%b, want %0d",
                     nm, cyc, done, N_FULL + 1);
        end
        e = sig_q.pop_front();
        n_checks++;
        if (misr !== e || cnt !== CW_F'(N_FULL)) begin
            n_fail++;
            $display("FAIL %s_sig: got %h cnt %0d, want %h cnt %0d",
                     nm, misr, cnt, e, N_FULL);
        end
        n_checks++;
        if (fault !== (e != GOLD)) begin
            n_fail++;
            $display("FAIL %s_verdict: got %b, want %b", nm, fault, e != GOLD);
        end
        got_sig = misr;
    endtask

    task automatic test_clean_and_stuck();
        logic [RES_W-1:0] s;
        run_full(1'b0, "clean", sig_clean);
        run_full(1'b1, "stuck", s);
        inject = 1'b0;
        n_checks++;
        if (s === sig_clean) begin
            n_fail++;
            $display("FAIL stuck_differs: got %h, want not %h", s, sig_clean);
        end
    endtask

    task automatic test_abort();
        logic [RES_W-1:0] held;
        int i;
        push_run(N_FULL, 1'b0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        i = 0;
        while (i < 100) begin
            check_pat(pat, "abort_pat");
            n_checks++;
            if (cnt !== CW_F'(i) || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL abort_cnt: got %0d busy %b, want %0d 1",
                         cnt, busy, i);
            end
            start = (i == 20) || (i == 21);
            @(negedge clk);
            i++;
        end
        held = misr;
        mode = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({pv, busy, done, fault} !== 4'b0 || cnt !== CW_F'(100)
            || misr !== held) begin
            n_fail++;
            $display("FAIL abort_idle: got %b cnt %0d sig %h, want 0 100 %h",
                     {pv, busy, done, fault}, cnt, misr, held);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_nomode: got busy %b, want 0", busy);
        end
        mode = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset_midrun();
        logic [RES_W-1:0] s;
        int i;
        push_run(N_FULL, 1'b0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (i = 0; i < 50; i++) begin
            check_pat(pat, "rst_pat");
            @(negedge clk);
        end
        rst = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (pat !== 9'h1FF || {pv, busy, done, fault, misr, cnt} !== '0) begin
            n_fail++;
            $display("FAIL rst_mid: got pat %h outs %b, want 1ff 0",
                     pat, {pv, busy, done, fault, misr, cnt});
        end
        rst = 1'b0;
        @(negedge clk);
        run_full(1'b0, "rerun", s);
        n_checks++;
        if (s !== sig_clean) begin
            n_fail++;
            $display("FAIL rerun_match: got %h, want %h", s, sig_clean);
        end
    endtask

    initial begin
        test_reset();
        test_small_run();
        test_clean_and_stuck();
        test_abort();
        test_reset_midrun();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
